// File: rtl/iob_cpu_bus_adapter.sv
// rtl/iob_cpu_bus_adapter.sv - CPU cmd/rsp port to IOb native bus bridge
// Commands get strobes, remap and an alignment flag on entry; the FIFO head is issued one at a time.
module iob_cpu_bus_adapter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int REMAP_EN = 0,
  parameter int E_BIT    = ADDR_W - 2,
  parameter int P_BIT    = ADDR_W - 3,
  localparam int NB      = DATA_W / 8,
  localparam int PW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot,
  input  logic              cpu_cmd_valid,
  output logic              cpu_cmd_ready,
  input  logic              cpu_cmd_wr,
  input  logic [ADDR_W-1:0] cpu_cmd_addr,
  input  logic [DATA_W-1:0] cpu_cmd_wdata,
  input  logic [1:0]        cpu_cmd_size,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_error,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [NB-1:0]     mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [PW-1:0]     pending
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            state_q;
  logic [IW-1:0]     wr_ptr_q, rd_ptr_q, nxt_ptr;
  logic [PW-1:0]     pending_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [NB-1:0]     mem_wstrb_q;
  logic              rsp_valid_q, rsp_error_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              fifo_wr    [DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [DEPTH];
  logic [DATA_W-1:0] fifo_wdata [DEPTH];
  logic [NB-1:0]     fifo_wstrb [DEPTH];
  logic              fifo_err   [DEPTH];

  int                in_n;
  logic [ADDR_W-1:0] in_off, in_addr;
  logic [NB-1:0]     in_lanes, in_wstrb;
  logic              in_err;

  logic              push, pop, fifo_empty, head_avail, nxt_avail;
  logic              head_wr, head_err, nxt_err;
  logic [ADDR_W-1:0] head_addr, nxt_addr;
  logic [DATA_W-1:0] head_wdata, nxt_wdata;
  logic [NB-1:0]     head_wstrb, nxt_wstrb;

  always_comb begin
    in_n     = 1 << cpu_cmd_size;
    in_off   = cpu_cmd_addr & ADDR_W'(NB - 1);
    in_lanes = '0;
    for (int b = 0; b < NB; b++) begin
      in_lanes[b] = (ADDR_W'(b) >= in_off) && (ADDR_W'(b) < in_off + ADDR_W'(in_n));
    end
    in_wstrb = cpu_cmd_wr ? in_lanes : '0;
    in_err   = ((cpu_cmd_addr & ADDR_W'(in_n - 1)) != '0) || (in_n > NB);
    in_addr  = cpu_cmd_addr;
    // Peripheral space is never remapped; otherwise boot flips the external-memory select.
    if (REMAP_EN != 0) begin
      in_addr[ADDR_W-1] = (cpu_cmd_addr[E_BIT] ^ ~boot) & ~cpu_cmd_addr[P_BIT];
    end
  end

  // An empty FIFO forwards the incoming command so issue starts the cycle after acceptance.
  always_comb begin
    push       = cpu_cmd_valid && cpu_cmd_ready;
    fifo_empty = (pending_q == '0);
    head_avail = !fifo_empty || push;
    nxt_ptr    = rd_ptr_q + IW'(1);
    nxt_avail  = (pending_q > PW'(1)) || push;
    if (fifo_empty) begin
      head_wr    = cpu_cmd_wr;
      head_addr  = in_addr;
      head_wdata = cpu_cmd_wdata;
      head_wstrb = in_wstrb;
      head_err   = in_err;
    end else begin
      head_wr    = fifo_wr[rd_ptr_q];
      head_addr  = fifo_addr[rd_ptr_q];
      head_wdata = fifo_wdata[rd_ptr_q];
      head_wstrb = fifo_wstrb[rd_ptr_q];
      head_err   = fifo_err[rd_ptr_q];
    end
    if (pending_q > PW'(1)) begin
      nxt_addr  = fifo_addr[nxt_ptr];
      nxt_wdata = fifo_wdata[nxt_ptr];
      nxt_wstrb = fifo_wstrb[nxt_ptr];
      nxt_err   = fifo_err[nxt_ptr];
    end else begin
      nxt_addr  = in_addr;
      nxt_wdata = cpu_cmd_wdata;
      nxt_wstrb = in_wstrb;
      nxt_err   = in_err;
    end
    pop = (state_q == S_IDLE) ? (head_avail && head_err) : mem_ready;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr_q]    <= cpu_cmd_wr;
      fifo_addr[wr_ptr_q]  <= in_addr;
      fifo_wdata[wr_ptr_q] <= cpu_cmd_wdata;
      fifo_wstrb[wr_ptr_q] <= in_wstrb;
      fifo_err[wr_ptr_q]   <= in_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + IW'(1);
      if (pop) rd_ptr_q <= nxt_ptr;
      pending_q <= pending_q + PW'(push) - PW'(pop);
      case (state_q)
        S_IDLE: begin
          if (head_avail) begin
            if (head_err) begin
              rsp_error_q <= 1'b1;
              rsp_valid_q <= ~head_wr;
              if (!head_wr) rsp_rdata_q <= '0;
            end else begin
              state_q     <= S_ISSUE;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= head_addr;
              mem_wdata_q <= head_wdata;
              mem_wstrb_q <= head_wstrb;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            rsp_valid_q <= ~head_wr;
            if (!head_wr) rsp_rdata_q <= mem_rdata;
            if (nxt_avail && !nxt_err) begin
              mem_addr_q  <= nxt_addr;
              mem_wdata_q <= nxt_wdata;
              mem_wstrb_q <= nxt_wstrb;
            end else begin
              state_q     <= S_IDLE;
              mem_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_cmd_ready = !rst && (pending_q < PW'(DEPTH));
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_error = rsp_error_q;
  assign cpu_rsp_rdata = rsp_rdata_q;
  assign mem_valid     = mem_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_iob_cpu_bus_adapter.sv
// tb/tb_iob_cpu_bus_adapter.sv - scoreboard bench for iob_cpu_bus_adapter
module tb_iob_cpu_bus_adapter;
  localparam int NBT = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot = 1'b0;
  logic        cpu_cmd_valid = 1'b0;
  logic        cpu_cmd_ready;
  logic        cpu_cmd_wr = 1'b0;
  logic [31:0] cpu_cmd_addr = '0;
  logic [31:0] cpu_cmd_wdata = '0;
  logic [1:0]  cpu_cmd_size = '0;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        cpu_rsp_error;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  pending;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   rd_done[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   mem_wcnt = 0;
  logic mem_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_cpu_bus_adapter #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(2), .REMAP_EN(1), .E_BIT(30), .P_BIT(29)
  ) dut (
    .clk(clk), .rst(rst), .boot(boot),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
    .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_wdata(cpu_cmd_wdata), .cpu_cmd_size(cpu_cmd_size),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_error(cpu_rsp_error),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pending(pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return a ^ 32'hDEADBEEF ^ {a[15:0], a[31:16]};
  endfunction

  // Reference: what one accepted command must produce on the bus and on the response port.
  task automatic expect_cmd(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd, input logic bt);
    int n;
    logic err;
    logic [15:0] lanes;
    logic [31:0] at;
    bus_t b;
    rsp_t r;
    n = 1 << sz;
    err = ((a % n) != 0) || (n > NBT);
    lanes = ((16'd1 << n) - 16'd1) << (a % NBT);
    at = a;
    if (a[29]) at[31] = 1'b0;
    else at[31] = bt ? a[30] : ~a[30];
    if (!err) begin
      b.addr = at;
      b.wdata = wd;
      b.strb = wr ? lanes[3:0] : 4'd0;
      exp_bus.push_back(b);
    end
    if (err || !wr) begin
      r.v = !wr;
      r.e = err;
      r.d = err ? 32'd0 : mem_func(at);
      exp_rsp.push_back(r);
    end
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input logic bt);
    logic acc;
    int tries;
    @(negedge clk);
    cpu_cmd_valid = 1'b1;
    cpu_cmd_wr = wr;
    cpu_cmd_addr = a;
    cpu_cmd_size = sz;
    cpu_cmd_wdata = wd;
    boot = bt;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 300) begin
      #1 acc = cpu_cmd_ready;
      @(posedge clk);
      if (!acc) begin
        tries++;
        @(negedge clk);
      end
    end
    if (acc) expect_cmd(wr, a, sz, wd, bt);
    else fail("accept_timeout");
  endtask

  task automatic idle();
    @(negedge clk);
    cpu_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_bus.size() != 0 || exp_rsp.size() != 0 || pending != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) fail("drain_timeout");
  endtask

  // Memory: answers after a random wait, returns data derived from the address, and
  // throws in stray mem_ready pulses while no request is up.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!rst) begin
        if (mem_valid) begin
          if (mem_en) begin
            if (mem_wcnt > 0) mem_wcnt--;
            else begin
              if (exp_bus.size() == 0) fail("bus_unexpected");
              else begin
                b = exp_bus.pop_front();
                chk("mem_addr", mem_addr, b.addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(b.strb));
                if (b.strb != 4'd0) chk("mem_wdata", mem_wdata, b.wdata);
              end
              mem_rdata = mem_func(mem_addr);
              mem_ready = 1'b1;
              if (mem_wstrb == 4'd0) rd_done.push_back(cyc);
              mem_wcnt = $urandom_range(0, 3);
            end
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_rdata = $urandom();
          mem_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    rsp_t r;
    int t;
    forever begin
      @(negedge clk);
      if (!rst && (cpu_rsp_valid || cpu_rsp_error)) begin
        if (exp_rsp.size() == 0) fail("rsp_unexpected");
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_valid", 32'(cpu_rsp_valid), 32'(r.v));
          chk("rsp_error", 32'(cpu_rsp_error), 32'(r.e));
          if (r.v) chk("rsp_rdata", cpu_rsp_rdata, r.d);
          if (r.v && !r.e) begin
            if (rd_done.size() == 0) fail("rsp_without_bus_read");
            else begin
              t = rd_done.pop_front();
              chk("rsp_latency", 32'(cyc), 32'(t + 1));
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_cmd_ready", 32'(cpu_cmd_ready), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("reset_rsp_error", 32'(cpu_rsp_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_cmd_ready", 32'(cpu_cmd_ready), 32'd1);
    chk("release_pending", 32'(pending), 32'd0);
    mem_en = 1'b1;

    send(1'b1, 32'h103, 2'd0, 32'h44444444, 1'b1);
    send(1'b1, 32'h102, 2'd1, 32'h33333333, 1'b1);
    send(1'b1, 32'h104, 2'd2, 32'h12345678, 1'b1);
    idle();
    wait_drain();

    send(1'b0, 32'h100, 2'd2, 32'h0, 1'b1);
    #1 chk("issue_latency", 32'(mem_valid), 32'd1);
    idle();
    wait_drain();

    send(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
    #1 chk("remap_boot0", mem_addr, 32'h80000010);
    idle();
    wait_drain();
    send(1'b0, 32'h20000000, 2'd2, 32'h0, 1'b0);
    #1 chk("remap_periph", mem_addr, 32'h20000000);
    idle();
    wait_drain();
    send(1'b0, 32'h10, 2'd2, 32'h0, 1'b1);
    #1 chk("remap_boot1", mem_addr, 32'h00000010);
    idle();
    wait_drain();

    mem_en = 1'b0;
    send(1'b0, 32'h100, 2'd2, 32'h0, 1'b1);
    send(1'b0, 32'h104, 2'd2, 32'h0, 1'b1);
    @(negedge clk);
    cpu_cmd_addr = 32'h108;
    #1;
    chk("full_cmd_ready", 32'(cpu_cmd_ready), 32'd0);
    chk("full_pending", 32'(pending), 32'd2);
    repeat (3) @(negedge clk);
    #1 chk("full_pending_hold", 32'(pending), 32'd2);
    idle();
    mem_en = 1'b1;
    send(1'b0, 32'h108, 2'd2, 32'h0, 1'b1);
    idle();
    wait_drain();

    mem_en = 1'b0;
    send(1'b0, 32'h100, 2'd2, 32'h0, 1'b1);
    send(1'b0, 32'h102, 2'd2, 32'h0, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    mem_en = 1'b1;
    wait_drain();

    mem_en = 1'b0;
    send(1'b0, 32'h200, 2'd2, 32'h0, 1'b1);
    idle();
    #1 chk("issue_before_rst", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    #1 chk("rst_drops_mem_valid", 32'(mem_valid), 32'd0);
    exp_bus.delete();
    exp_rsp.delete();
    rd_done.delete();
    mem_wcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cmd_ready", 32'(cpu_cmd_ready), 32'd1);
    mem_en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0] sz;
      int g;
      g = $urandom_range(0, 3);
      if (g > 1) repeat (g - 1) idle();
      sz = 2'($urandom_range(0, 3));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      send(1'($urandom_range(0, 1)), a, sz, $urandom(), 1'($urandom_range(0, 1)));
    end
    idle();
    wait_drain();
    repeat (3) @(negedge clk);
    chk("final_rsp_queue", 32'(exp_rsp.size()), 32'd0);
    chk("final_bus_queue", 32'(exp_bus.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
